// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped 8N1 UART with TX/RX FIFOs, W1C status and level interrupt.
module uart_fifo_mmio #(
    parameter int ADDR_W = 32,
    parameter int XLEN = 32,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0100,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmio_req,
    input  logic              mmio_we,
    input  logic [ADDR_W-1:0] mmio_addr,
    input  logic [XLEN-1:0]   mmio_wdata,
    output logic [XLEN-1:0]   mmio_rdata,
    output logic              mmio_ready,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              irq
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0] tx_cnt;
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0] rx_cnt;
    logic [1:0] ctrl;
    logic [15:0] div, div_eff;
    logic [2:0] sticky, stat_clr;
    logic [7:0] off, stat, rx_head;
    logic [XLEN-1:0] rd_val;
    logic hit, wr, rd, tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, tx_drop_set;
    logic rx_pop, rx_push, rx_good, rx_ovr_set, rx_ferr_set, tx_active, tx_busy, tx_last, rx_last, rx_half;
    state_t ts, rs;
    logic [15:0] tcnt, tdiv, rcnt, rdiv;
    logic [2:0] tbit, rbit;
    logic [7:0] tsh, rsh;
    logic tx_q, s1, s2, s2_d;
    logic unused_bits;
    assign unused_bits = ^mmio_wdata[XLEN-1:16];
    assign hit = mmio_req && mmio_addr[ADDR_W-1:8] == BASE[ADDR_W-1:8];
    assign off = mmio_addr[7:0];
    assign wr = hit && mmio_we;
    assign rd = hit && !mmio_we;
    assign tx_full = tx_cnt == (TAW+1)'(TX_DEPTH);
    assign tx_empty = tx_cnt == '0;
    assign rx_full = rx_cnt == (RAW+1)'(RX_DEPTH);
    assign rx_empty = rx_cnt == '0;
    assign rx_head = rx_mem[rx_rp];
    assign div_eff = div < 16'd4 ? 16'd4 : div;
    assign tx_push = wr && off == 8'h00 && !tx_full;
    assign tx_drop_set = wr && off == 8'h00 && tx_full;
    assign rx_pop = rd && off == 8'h04 && !rx_empty;
    assign stat_clr = (wr && off == 8'h08) ? mmio_wdata[7:5] : 3'b000;
    assign tx_active = ts != IDLE;
    assign tx_busy = tx_active || !tx_empty;
    assign stat = {sticky, rx_full, !rx_empty, tx_empty, tx_full, tx_busy};
    assign irq = (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty && !tx_active);
    assign uart_tx = tx_q;
    always_comb begin
        rd_val = !rd ? '0 :
                 off == 8'h04 ? XLEN'({!rx_empty, rx_empty ? 8'h00 : rx_head}) :
                 off == 8'h08 ? XLEN'(stat) :
                 off == 8'h0C ? XLEN'(ctrl) :
                 off == 8'h10 ? XLEN'(div) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_ready <= 1'b0;
            mmio_rdata <= '0;
            ctrl <= 2'b00;
            div <= DIV_RESET;
            sticky <= 3'b000;
        end else begin
            mmio_ready <= mmio_req;
            mmio_rdata <= rd_val;
            if (wr && off == 8'h0C) ctrl <= mmio_wdata[1:0];
            if (wr && off == 8'h10) div <= mmio_wdata[15:0];
            sticky <= (sticky & ~stat_clr) | {rx_ferr_set, tx_drop_set, rx_ovr_set};
        end
    end
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= mmio_wdata[7:0];
        if (rx_push) rx_mem[rx_wp] <= rsh;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            tx_cnt <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop) tx_rp <= tx_rp + TAW'(1);
            tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop) rx_rp <= rx_rp + RAW'(1);
            rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
        end
    end
    // A frame may start straight out of STOP so back-to-back bytes have no idle gap.
    assign tx_last = tcnt == tdiv - 16'd1;
    assign tx_pop = !tx_empty && (ts == IDLE || (ts == STOP && tx_last));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= IDLE;
            tcnt <= '0;
            tdiv <= 16'd4;
            tbit <= '0;
            tsh <= '0;
            tx_q <= 1'b1;
        end else if (tx_pop) begin
            ts <= START;
            tsh <= tx_mem[tx_rp];
            tdiv <= div_eff;
            tcnt <= '0;
            tx_q <= 1'b0;
        end else if (tx_active) begin
            tcnt <= tx_last ? '0 : tcnt + 16'd1;
            if (tx_last) begin
                case (ts)
                    START: begin
                        ts <= DATA;
                        tbit <= '0;
                        tx_q <= tsh[0];
                    end
                    DATA: begin
                        tbit <= tbit + 3'd1;
                        tsh <= tsh >> 1;
                        tx_q <= tbit == 3'd7 ? 1'b1 : tsh[1];
                        if (tbit == 3'd7) ts <= STOP;
                    end
                    default: begin
                        ts <= IDLE;
                        tx_q <= 1'b1;
                    end
                endcase
            end
        end
    end
    // Data and stop bits are sampled mid-bit: half a bit after the start edge, then every DIV.
    assign rx_last = rcnt == rdiv - 16'd1;
    assign rx_half = rcnt == (rdiv >> 1) - 16'd1;
    assign rx_good = rs == STOP && rx_last && s2;
    assign rx_ferr_set = rs == STOP && rx_last && !s2;
    assign rx_push = rx_good && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_good && rx_full && !rx_pop;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s2_d <= 1'b1;
            rs <= IDLE;
            rcnt <= '0;
            rdiv <= 16'd4;
            rbit <= '0;
            rsh <= '0;
        end else begin
            s1 <= uart_rx;
            s2 <= s1;
            s2_d <= s2;
            case (rs)
                IDLE: if (s2_d && !s2) begin
                    rs <= START;
                    rcnt <= '0;
                    rdiv <= div_eff;
                end
                START: begin
                    rcnt <= rx_half ? '0 : rcnt + 16'd1;
                    rbit <= '0;
                    if (rx_half) rs <= s2 ? IDLE : DATA;
                end
                DATA: begin
                    rcnt <= rx_last ? '0 : rcnt + 16'd1;
                    if (rx_last) begin
                        rsh <= {s2, rsh[7:1]};
                        rbit <= rbit + 3'd1;
                        if (rbit == 3'd7) rs <= STOP;
                    end
                end
                default: begin
                    rcnt <= rx_last ? '0 : rcnt + 16'd1;
                    if (rx_last) rs <= IDLE;
                end
            endcase
        end
    end
endmodule
